// File: rtl/cmos_multi_obj_box.sv
// cmos_multi_obj_box
//   Multi-class colour locator on the camera pixel stream. Each RGB565 pixel
//   is tested against NUM_CLASS programmable colour windows. Every class keeps
//   its own bounding box and saturating pixel count for the current frame.
//   A rising edge of frame_vsync marks a frame boundary. At that point the
//   live accumulators are copied into a result bank, and the bank is then
//   reported one class per beat over a valid/ready port.
//
// Ports
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   frame_vsync     frame sync; its rising edge is the frame boundary
//   pix_valid       pix_data qualifier (ignored while frame_vsync is high)
//   pix_data        RGB565 pixel {R[15:11], G[10:5], B[4:0]}
//   h_pixel         active line length in pixels (>= 1)
//   thr_lo/thr_hi   per-class inclusive RGB565 window, class k at [16k+15:16k]
//   min_area        minimum pixel count for a class to be reported as found
//   res_ready       consumer accepts the current beat
//   res_*           result beat: class, found flag, box (0 when not found), count
//   frame_drop      one-cycle pulse when a finished frame is discarded because
//                   the previous report has not completed
module cmos_multi_obj_box #(
  parameter int NUM_CLASS = 3,
  parameter int XW        = 11,
  parameter int YW        = 11,
  parameter int CNT_W     = 20,
  parameter int CLS_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_vsync,
  input  logic                    pix_valid,
  input  logic [15:0]             pix_data,
  input  logic [XW-1:0]           h_pixel,
  input  logic [NUM_CLASS*16-1:0] thr_lo,
  input  logic [NUM_CLASS*16-1:0] thr_hi,
  input  logic [CNT_W-1:0]        min_area,
  input  logic                    res_ready,
  output logic                    res_valid,
  output logic [CLS_W-1:0]        res_class,
  output logic                    res_found,
  output logic [XW-1:0]           res_x_min,
  output logic [XW-1:0]           res_x_max,
  output logic [YW-1:0]           res_y_min,
  output logic [YW-1:0]           res_y_max,
  output logic [CNT_W-1:0]        res_count,
  output logic                    frame_drop
);

  localparam logic [XW-1:0]    X_ONE    = XW'(1);
  localparam logic [YW-1:0]    Y_ONE    = YW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CLS_W-1:0] CLS_ONE  = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CLS_W-1:0] idx_reg, idx_next;
  logic             frame_drop_reg, drop_next;
  logic             load_bank;

  logic             vs_d_reg;
  logic             vs_rise;
  logic [XW-1:0]    x_reg;
  logic [YW-1:0]    y_reg;
  logic             pix_count;
  logic             accum_en;
  logic             handshake;
  logic             last_beat;

  // Banked results of all classes, flattened so the output mux can pick one.
  logic [NUM_CLASS*XW-1:0]    bank_x_min_flat;
  logic [NUM_CLASS*XW-1:0]    bank_x_max_flat;
  logic [NUM_CLASS*YW-1:0]    bank_y_min_flat;
  logic [NUM_CLASS*YW-1:0]    bank_y_max_flat;
  logic [NUM_CLASS*CNT_W-1:0] bank_cnt_flat;

  assign vs_rise   = frame_vsync & ~vs_d_reg;
  assign pix_count = pix_valid & ~frame_vsync;
  assign accum_en  = pix_count & (state_reg != IDLE);
  assign handshake = (state_reg == REPORT) & res_ready;
  assign last_beat = (idx_reg == CLS_LAST);

  // Frame edge detect and raster coordinates of the next counted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_reg <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else begin
      vs_d_reg <= frame_vsync;
      if (vs_rise) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (pix_count) begin
        if (x_reg == h_pixel - X_ONE) begin
          x_reg <= '0;
          if (y_reg != '1) begin
            y_reg <= y_reg + Y_ONE;
          end
        end else begin
          x_reg <= x_reg + X_ONE;
        end
      end
    end
  end

  // Per-class window match, live accumulator and result bank.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_class
      logic [15:0]      lo;
      logic [15:0]      hi;
      logic             hit;
      logic [XW-1:0]    live_x_min_reg, live_x_max_reg;
      logic [YW-1:0]    live_y_min_reg, live_y_max_reg;
      logic [CNT_W-1:0] live_cnt_reg;
      logic [XW-1:0]    bank_x_min_reg, bank_x_max_reg;
      logic [YW-1:0]    bank_y_min_reg, bank_y_max_reg;
      logic [CNT_W-1:0] bank_cnt_reg;

      assign lo = thr_lo[gi*16 +: 16];
      assign hi = thr_hi[gi*16 +: 16];

      // Fields compared independently; an inverted window on any field
      // can never be satisfied, which disables the class.
      assign hit = (pix_data[15:11] >= lo[15:11]) && (pix_data[15:11] <= hi[15:11]) &&
                   (pix_data[10:5]  >= lo[10:5])  && (pix_data[10:5]  <= hi[10:5])  &&
                   (pix_data[4:0]   >= lo[4:0])   && (pix_data[4:0]   <= hi[4:0]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          live_x_min_reg <= '1;
          live_x_max_reg <= '0;
          live_y_min_reg <= '1;
          live_y_max_reg <= '0;
          live_cnt_reg   <= '0;
          bank_x_min_reg <= '0;
          bank_x_max_reg <= '0;
          bank_y_min_reg <= '0;
          bank_y_max_reg <= '0;
          bank_cnt_reg   <= '0;
        end else begin
          // A frame boundary always restarts the live set; no pixel is
          // counted in that cycle because frame_vsync is high.
          if (vs_rise) begin
            live_x_min_reg <= '1;
            live_x_max_reg <= '0;
            live_y_min_reg <= '1;
            live_y_max_reg <= '0;
            live_cnt_reg   <= '0;
          end else if (accum_en && hit) begin
            if (x_reg < live_x_min_reg) live_x_min_reg <= x_reg;
            if (x_reg > live_x_max_reg) live_x_max_reg <= x_reg;
            if (y_reg < live_y_min_reg) live_y_min_reg <= y_reg;
            if (y_reg > live_y_max_reg) live_y_max_reg <= y_reg;
            if (live_cnt_reg != '1) live_cnt_reg <= live_cnt_reg + CNT_ONE;
          end
          // Captures the pre-clear live values of the frame just ended.
          if (load_bank) begin
            bank_x_min_reg <= live_x_min_reg;
            bank_x_max_reg <= live_x_max_reg;
            bank_y_min_reg <= live_y_min_reg;
            bank_y_max_reg <= live_y_max_reg;
            bank_cnt_reg   <= live_cnt_reg;
          end
        end
      end

      assign bank_x_min_flat[gi*XW +: XW]       = bank_x_min_reg;
      assign bank_x_max_flat[gi*XW +: XW]       = bank_x_max_reg;
      assign bank_y_min_flat[gi*YW +: YW]       = bank_y_min_reg;
      assign bank_y_max_flat[gi*YW +: YW]       = bank_y_max_reg;
      assign bank_cnt_flat[gi*CNT_W +: CNT_W]   = bank_cnt_reg;
    end
  endgenerate

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      frame_drop_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_drop_reg <= drop_next;
    end
  end

  // FSM: next state.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_bank  = 1'b0;
    drop_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vs_rise) state_next = ACCUM;
      end
      ACCUM: begin
        if (vs_rise) begin
          state_next = REPORT;
          idx_next   = '0;
          load_bank  = 1'b1;
        end
      end
      REPORT: begin
        if (handshake) begin
          if (last_beat) begin
            // A boundary landing on the final beat starts the next report
            // straight away instead of being dropped.
            if (vs_rise) begin
              idx_next  = '0;
              load_bank = 1'b1;
            end else begin
              state_next = ACCUM;
            end
          end else begin
            idx_next = idx_reg + CLS_ONE;
          end
        end
        if (vs_rise && !(handshake && last_beat)) drop_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM: outputs, selected from the bank entry of the current beat.
  logic [XW-1:0]    sel_x_min, sel_x_max;
  logic [YW-1:0]    sel_y_min, sel_y_max;
  logic [CNT_W-1:0] sel_cnt;

  always_comb begin
    sel_x_min = '0;
    sel_x_max = '0;
    sel_y_min = '0;
    sel_y_max = '0;
    sel_cnt   = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (idx_reg == CLS_W'(k)) begin
        sel_x_min = bank_x_min_flat[k*XW +: XW];
        sel_x_max = bank_x_max_flat[k*XW +: XW];
        sel_y_min = bank_y_min_flat[k*YW +: YW];
        sel_y_max = bank_y_max_flat[k*YW +: YW];
        sel_cnt   = bank_cnt_flat[k*CNT_W +: CNT_W];
      end
    end
    res_valid  = (state_reg == REPORT);
    res_class  = idx_reg;
    frame_drop = frame_drop_reg;
    res_found  = (sel_cnt != '0) && (sel_cnt >= min_area);
    res_x_min  = res_found ? sel_x_min : '0;
    res_x_max  = res_found ? sel_x_max : '0;
    res_y_min  = res_found ? sel_y_min : '0;
    res_y_max  = res_found ? sel_y_max : '0;
    res_count  = sel_cnt;
  end

endmodule
